// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  localparam logic [3:0]  HDR_TAG         = 4'hA;
  localparam int unsigned WAIT_HI_TIMEOUT = 3;

  function automatic logic [7:0] hdr_byte(input logic [2:0] gid);
    return {HDR_TAG, 1'b0, gid};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    sum   = '0;
    idx   = '0;
    any   = 1'b0;
    grant = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        idx = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
      end
    end
    if (any) grant = N'(1) << idx;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one async_transmitter between NUM_REQ word requesters, LSB first.
// Optional per-word header byte enabled by defining UART_TX_ARB_HEADER_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*8*WORD_BYTES-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          tx_busy,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WORD_W = 8 * WORD_BYTES;
`ifdef UART_TX_ARB_HEADER_EN
  localparam logic       HDR_EN   = 1'b1;
  localparam logic [2:0] CNT_INIT = 3'(WORD_BYTES);
`else
  localparam logic       HDR_EN   = 1'b0;
  localparam logic [2:0] CNT_INIT = 3'(WORD_BYTES - 1);
`endif

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic               hdr_q, hdr_d;
  logic [1:0]         tmo_q, tmo_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [WORD_W-1:0]  word_sel;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (gnt_oh[i]) word_sel = req_data[i*WORD_W +: WORD_W];
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    hdr_d   = hdr_q;
    tmo_d   = tmo_q;
    ready_d = '0;
    start_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = START;
          shift_d = word_sel;
          gid_d   = ID_W'(gnt_idx);
          ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          ready_d = gnt_oh;
          cnt_d   = CNT_INIT;
          hdr_d   = HDR_EN;
        end
      end
      // Busy here can be a byte still in flight from before a reset; hold until it drains.
      START: begin
        if (!tx_busy) begin
          start_d = 1'b1;
          data_d  = hdr_q ? hdr_byte(3'(gid_q)) : shift_q[7:0];
          tmo_d   = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy)
          state_d = WAIT_LO;
        else if (tmo_q == 2'(WAIT_HI_TIMEOUT - 1))
          state_d = START;
        else
          tmo_d = tmo_q + 1'b1;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d = START;
            cnt_d   = cnt_q - 1'b1;
            if (hdr_q) hdr_d = 1'b0;
            else       shift_d = shift_q >> 8;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      hdr_q   <= 1'b0;
      tmo_q   <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      hdr_q   <= hdr_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign req_ready = ready_q;
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int WB       = 4;
  localparam int BYTE_CYC = 20;
  localparam int HDR =
`ifdef UART_TX_ARB_HEADER_EN
    1;
`else
    0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*8*WB-1:0] req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              busy;
  logic [1:0]        grant_id;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .WORD_BYTES (WB),
    .ID_W       (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the cycle after a start, for BYTE_CYC cycles.
  int   busy_cnt    = 0;
  int   start_count = 0;
  int   ignore_idx  = -1;
  logic force_busy  = 1'b0;

  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (tx_start) begin
      start_count <= start_count + 1;
      if (start_count != ignore_idx) busy_cnt <= BYTE_CYC;
    end
  end

  assign tx_busy = force_busy || (busy_cnt > 0);

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0;
  int n_ready = 0;
  int grants_left = 0;
  bit hold_valid = 1'b0;
  logic prev_txb = 1'b0;
  logic prev_busy = 1'b0;
  int txb_fall_cyc = 0;
  int busy_fall_cyc = 0;
  logic [7:0] exp_b[$];
  int         exp_g[$];
  int         start_cyc_q[$];

  task automatic push_word(input int r, input logic [31:0] w, input bit dup_first);
    logic [7:0] b;
    exp_g.push_back(r);
    req_data[r*32 +: 32] = w;
    if (HDR != 0) begin
      b = {4'hA, 1'b0, 3'(r)};
      exp_b.push_back(b);
      if (dup_first) exp_b.push_back(b);
    end
    for (int i = 0; i < WB; i++) begin
      b = w[8*i +: 8];
      exp_b.push_back(b);
      if (dup_first && i == 0 && HDR == 0) exp_b.push_back(b);
    end
  endtask

  task automatic step();
    logic [7:0] e;
    int g;
    @(negedge clk);
    cyc++;
    if (prev_txb && !tx_busy) txb_fall_cyc = cyc;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_txb  = tx_busy;
    prev_busy = busy;
    if (tx_start) begin
      n_start++;
      start_cyc_q.push_back(cyc);
      checks++;
      if (tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL start_while_busy: tx_busy=%b required 0 at cycle %0d", tx_busy, cyc);
      end
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: tx_data=%h with empty expectation queue", tx_data);
      end else begin
        e = exp_b.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL byte_data: tx_data=%h required %h", tx_data, e);
        end
      end
    end
    if (req_ready !== '0) begin
      n_ready++;
      checks++;
      if (exp_g.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: req_ready=%b with no grant expected", req_ready);
      end else begin
        g = exp_g.pop_front();
        if (req_ready !== 4'(1 << g)) begin
          errors++;
          $display("FAIL ready_onehot: req_ready=%b required %b", req_ready, 4'(1 << g));
        end
        checks++;
        if (grant_id !== 2'(g)) begin
          errors++;
          $display("FAIL grant_id: grant_id=%0d required %0d", grant_id, g);
        end
      end
      if (!hold_valid) req_valid = req_valid & ~req_ready;
      else begin
        grants_left--;
        if (grants_left == 0) req_valid = '0;
      end
    end
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int n = 0;
    while ((exp_b.size() != 0 || exp_g.size() != 0 || busy !== 1'b0 || tx_busy) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d bytes and %0d grants still pending after %0d cycles",
               name, exp_b.size(), exp_g.size(), budget);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (req_ready !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL %s: ready=%b start=%b data=%h busy=%b gid=%0d required all 0",
               name, req_ready, tx_start, tx_data, busy, grant_id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    step();
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_single();
    int r0;
    hold_valid = 1'b0;
    r0 = n_ready;
    push_word(2, 32'h11223344, 1'b0);
    req_valid[2] = 1'b1;
    run_to_idle("single", 400);
    checks++;
    if (n_ready - r0 != 1) begin
      errors++;
      $display("FAIL single_ready_count: pulses=%0d required 1", n_ready - r0);
    end
    checks++;
    if (busy_fall_cyc - txb_fall_cyc != 1) begin
      errors++;
      $display("FAIL single_busy_fall: busy fell %0d cycles after tx_busy, required 1",
               busy_fall_cyc - txb_fall_cyc);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] words[4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    int r0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_b.delete();
    exp_g.delete();
    hold_valid  = 1'b1;
    grants_left = 5;
    r0 = n_ready;
    for (int i = 0; i < 5; i++) push_word(i % 4, words[i % 4], 1'b0);
    req_valid = '1;
    run_to_idle("round_robin", 2500);
    hold_valid = 1'b0;
    checks++;
    if (n_ready - r0 != 5) begin
      errors++;
      $display("FAIL rr_ready_count: pulses=%0d required 5", n_ready - r0);
    end
  endtask

  task automatic test_busy_hold();
    int s0;
    force_busy = 1'b1;
    push_word(0, 32'h0F1E2D3C, 1'b0);
    req_valid[0] = 1'b1;
    s0 = n_start;
    repeat (50) step();
    checks++;
    if (n_start != s0) begin
      errors++;
      $display("FAIL hold_no_start: starts=%0d while busy, required 0", n_start - s0);
    end
    force_busy = 1'b0;
    s0 = n_start;
    repeat (15) step();
    checks++;
    if (n_start - s0 != 1) begin
      errors++;
      $display("FAIL hold_release_start: starts=%0d after release, required 1", n_start - s0);
    end
    run_to_idle("busy_hold", 400);
  endtask

  task automatic test_retry();
    int base;
    base = start_cyc_q.size();
    ignore_idx = start_count;
    push_word(1, 32'h55667788, 1'b1);
    req_valid[1] = 1'b1;
    run_to_idle("retry", 500);
    ignore_idx = -1;
    checks++;
    if (start_cyc_q.size() - base != WB + 1 + HDR) begin
      errors++;
      $display("FAIL retry_start_count: starts=%0d required %0d", start_cyc_q.size() - base, WB + 1 + HDR);
    end else begin
      checks++;
      if (start_cyc_q[base+1] - start_cyc_q[base] != 4) begin
        errors++;
        $display("FAIL retry_gap: gap=%0d cycles required 4", start_cyc_q[base+1] - start_cyc_q[base]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int s0;
    int n = 0;
    push_word(1, 32'h0A0B0C0D, 1'b0);
    req_valid[1] = 1'b1;
    s0 = n_start;
    while (n_start - s0 < 2 + HDR && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL midrst_wait: starts=%0d required %0d", n_start - s0, 2 + HDR);
    end
    rst = 1'b1;
    req_data[3*32 +: 32] = 32'h31323334;
    req_valid[3] = 1'b1;
    step();
    check_outputs_zero("midrst_outputs");
    exp_b.delete();
    exp_g.delete();
    rst = 1'b0;
    push_word(3, 32'h31323334, 1'b0);
    run_to_idle("midrst_regrant", 400);
  endtask

  task automatic test_header_word();
    push_word(1, 32'hDEADBEEF, 1'b0);
    req_valid[1] = 1'b1;
    run_to_idle("header_word", 400);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_hold();
    test_retry();
    test_mid_reset();
    test_header_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
